sliding_window_3x3: RTL and testbench
=====================================

# sliding_window_3x3

Upstream window generator for the 3x3 neighbourhood filter. It accepts a raster-order 8-bit pixel stream, one pixel per accepted cycle, and buffers the two previous image rows in internal line buffers. For every interior pixel position it presents a complete 3x3 window on `sw_pixels1..9` with a one-cycle `act` strobe, which directly drives the filter's `sw_pixels*` and `act` inputs. Border positions produce no window, so the filtered image is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

## Interface
- `IMG_WIDTH`, default 64: pixels per row; must be >= 3.
- `IMG_HEIGHT`, default 64: rows per frame; must be >= 3.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `en  in  1`: block enable; when low, no pixel is accepted and all state holds.
- `pix_valid  in  1`: `pix_in` is valid this cycle.
- `sof  in  1`: start of frame; qualifies the pixel accepted in the same cycle as position (0,0).
- `pix_in  in  8`: input pixel, raster order.
- `sw_pixels1 .. sw_pixels9  out  8 each`: window, row-major. 1 = top-left, 5 = centre, 9 = bottom-right.
- `act  out  1`: window valid; one-cycle pulse per interior window.
- `done  out  1`: one-cycle pulse when the last pixel of the frame has been accepted.

## Operation
- Accept condition: `en & pix_valid`. Nothing changes on cycles without an accept, except that `act` and `done` return to 0.
- Counters:
  - `col` counts 0..IMG_WIDTH-1 and `row` counts 0..IMG_HEIGHT-1, both registered.
  - On accept, `col` increments. At IMG_WIDTH-1, `col` wraps to 0 and `row` increments.
  - At the last pixel (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0, ready for the next frame.
- `sof` on an accept cycle: that pixel is treated as (0,0) regardless of the counter values, and the counters resume from (0,1). `sof` on a non-accept cycle is ignored.
- Line buffers:
  - `lb0` holds row-1 and `lb1` holds row-2. Each is IMG_WIDTH x 8, indexed by `col`.
  - On accept, read `lb1[col]` and `lb0[col]`, then write `lb1[col] <= lb0[col]` and `lb0[col] <= pix_in`.
  - Read-before-write within the same cycle is required.
  - Line buffer contents are not reset.
- Window register: a 3-column shift register.
  - On accept, each row shifts left by one column.
  - The new right column is {top = `lb1[col]`, middle = `lb0[col]`, bottom = `pix_in`}.
  - `sw_pixels3`, `sw_pixels6` and `sw_pixels9` are the newest column.
- Window validity: an accept at `row >= 2` and `col >= 2` (evaluated on the pre-increment counter values, after any `sof` override) completes the window centred at (row-1, col-1). That accept sets `act` for the next cycle.
- Accepts at `col` 0 or 1 shift in stale or previous-row data. This is allowed; `act` stays 0.
- `done` is set by the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1). It coincides with the final `act`.
- `sw_pixels*` hold their value between accepts. They are meaningful only while `act` = 1.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - Forces `sw_pixels1..9` = 0, `act` = 0, `done` = 0, `col` = 0, `row` = 0.
  - Released state begins a new frame at (0,0).
  - A reset mid-frame discards the partial frame. No `act` is produced until two new rows and three columns have been accepted.
- Latency: one clock from the accepting edge to `act`/`sw_pixels*`. The outputs are registered and update on the same edge that accepts the pixel.
- Throughput: one window per clock with continuous accepts. Gaps in `pix_valid` or `en` only delay the output; the window content is unchanged.
- No backpressure: the consumer must take every `act` pulse, since the filter pipeline is stall-free.
- `act` pulses per frame: exactly (IMG_WIDTH-2) x (IMG_HEIGHT-2).
- Simultaneous `sof` and last-pixel position: `sof` wins. The pixel is (0,0), and `done` does not fire.
- Intended implementation size: roughly 150–250 lines of RTL. The line buffers are inferred memory or register arrays.

## Test plan
- **Basic 4x4 frame.** IMG_WIDTH = IMG_HEIGHT = 4, pixel value = row*16 + col, continuous accepts, `sof` on the first pixel.
  - The first `act` comes one cycle after pixel (2,2): window = 00,01,02,10,11,12,20,21,22.
  - The second comes after (2,3): 01,02,03,11,12,13,21,22,23.
  - 4 `act` pulses total; `done` coincides with the last, window = 11,12,13,21,22,23,31,32,33.
- **Stalls.** Same frame, with `pix_valid` low every other cycle and `en` low for 5 cycles mid-row 2.
  - Identical window sequence and exactly 4 `act` pulses.
  - No `act` during any stall.
- **Back-to-back frames.** Two 4x4 frames with no gap; the second frame's pixel value = 0x80 + row*16 + col, no second `sof`.
  - The second frame's windows contain no first-frame data, e.g. its first window is 80,81,82,90,91,92,A0,A1,A2.
  - 8 `act` pulses and 2 `done` pulses.
- **Reset mid-frame.** Assert `rst_n` = 0 asynchronously (not on a clock edge) during row 2, then restart the frame.
  - Outputs read 0 immediately on reset.
  - The first post-reset `act` comes only after the new pixel (2,2), and its window is from the new frame only.
- **sof resync.** Assert `sof` at counter position (1,3) of a 4x4 frame.
  - That pixel becomes (0,0), and no `act` occurs for the next 9 accepts.
  - The following frame then yields 4 correct windows.
- **Minimum and non-square size.** IMG_WIDTH = 5, IMG_HEIGHT = 3.
  - Exactly 3 `act` pulses, centred at (1,1), (1,2), (1,3).
  - `done` arrives with the third pulse.

Source files
------------

// File: rtl/sliding_window_3x3.sv
// 3x3 window generator for a raster-order 8-bit pixel stream.
// Two line buffers supply the previous rows; a window is emitted for each interior pixel.
module sliding_window_3x3 #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pix_valid,
  input  logic       sof,
  input  logic [7:0] pix_in,
  output logic [7:0] sw_pixels1,
  output logic [7:0] sw_pixels2,
  output logic [7:0] sw_pixels3,
  output logic [7:0] sw_pixels4,
  output logic [7:0] sw_pixels5,
  output logic [7:0] sw_pixels6,
  output logic [7:0] sw_pixels7,
  output logic [7:0] sw_pixels8,
  output logic [7:0] sw_pixels9,
  output logic       act,
  output logic       done
);

  localparam int DATA_W = 8;
  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]  col, cur_col, col_nxt;
  logic [ROW_W-1:0]  row, cur_row, row_nxt;
  logic              accept, win_ok, frame_end;
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] top_p1 [3];
  logic [DATA_W-1:0] mid_p1 [3];
  logic [DATA_W-1:0] bot_p1 [3];
  logic              vld_p1, done_p1;

  // Stage 0: position of the incoming pixel (sof forces it to the frame origin)
  always_comb begin
    accept    = en & pix_valid;
    cur_col   = sof ? '0 : col;
    cur_row   = sof ? '0 : row;
    lb0_rd    = lb0[cur_col];
    lb1_rd    = lb1[cur_col];
    win_ok    = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    frame_end = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    col_nxt   = cur_col + COL_W'(1);
    row_nxt   = cur_row;
    if (cur_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
    end
  end

  // Line buffers are plain memory; reads above see the pre-write contents
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= lb0_rd;
      lb0[cur_col] <= pix_in;
    end
  end

  // Stage 1: registered window and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        top_p1[i] <= '0;
        mid_p1[i] <= '0;
        bot_p1[i] <= '0;
      end
    end else begin
      vld_p1  <= accept & win_ok;
      done_p1 <= accept & frame_end;
      if (accept) begin
        col       <= col_nxt;
        row       <= row_nxt;
        top_p1[0] <= top_p1[1];
        top_p1[1] <= top_p1[2];
        top_p1[2] <= lb1_rd;
        mid_p1[0] <= mid_p1[1];
        mid_p1[1] <= mid_p1[2];
        mid_p1[2] <= lb0_rd;
        bot_p1[0] <= bot_p1[1];
        bot_p1[1] <= bot_p1[2];
        bot_p1[2] <= pix_in;
      end
    end
  end

  assign sw_pixels1 = top_p1[0];
  assign sw_pixels2 = top_p1[1];
  assign sw_pixels3 = top_p1[2];
  assign sw_pixels4 = mid_p1[0];
  assign sw_pixels5 = mid_p1[1];
  assign sw_pixels6 = mid_p1[2];
  assign sw_pixels7 = bot_p1[0];
  assign sw_pixels8 = bot_p1[1];
  assign sw_pixels9 = bot_p1[2];
  assign act        = vld_p1;
  assign done       = done_p1;

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Directed bench for sliding_window_3x3: a 4x4 instance and a 5x3 instance share one input stream.
module tb_sliding_window_3x3;

  logic       clk = 1'b0;
  logic       rst_n, en, pix_valid, sof;
  logic [7:0] pix_in;
  logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
  logic       act_a, done_a, act_b, done_b;
  logic [71:0] win_a, win_b;

  always #5 clk = ~clk;

  sliding_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_valid(pix_valid), .sof(sof), .pix_in(pix_in),
    .sw_pixels1(a1), .sw_pixels2(a2), .sw_pixels3(a3), .sw_pixels4(a4), .sw_pixels5(a5),
    .sw_pixels6(a6), .sw_pixels7(a7), .sw_pixels8(a8), .sw_pixels9(a9),
    .act(act_a), .done(done_a));

  sliding_window_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_valid(pix_valid), .sof(sof), .pix_in(pix_in),
    .sw_pixels1(b1), .sw_pixels2(b2), .sw_pixels3(b3), .sw_pixels4(b4), .sw_pixels5(b5),
    .sw_pixels6(b6), .sw_pixels7(b7), .sw_pixels8(b8), .sw_pixels9(b9),
    .act(act_b), .done(done_b));

  assign win_a = {a1, a2, a3, a4, a5, a6, a7, a8, a9};
  assign win_b = {b1, b2, b3, b4, b5, b6, b7, b8, b9};

  logic [71:0] qa[$];
  logic [71:0] qb[$];
  bit          da[$];
  bit          dbq[$];
  int          done_a_cnt, done_b_cnt, stray;
  bit          acc_q;
  int          total, bad;

  always @(posedge clk) acc_q <= en & pix_valid;

  // Window capture away from the active edge
  always @(negedge clk) begin
    if (act_a) begin
      qa.push_back(win_a);
      da.push_back(done_a);
    end
    if (done_a) done_a_cnt++;
    if (act_a && !acc_q) stray++;
    if (act_b) begin
      qb.push_back(win_b);
      dbq.push_back(done_b);
    end
    if (done_b) done_b_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] mkwin(input int r, input int c, input logic [7:0] base);
    logic [71:0] w;
    w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        w = {w[63:0], 8'(int'(base) + (r + dr) * 16 + (c + dc))};
    return w;
  endfunction

  task automatic clear_mon();
    qa.delete(); qb.delete(); da.delete(); dbq.delete();
    done_a_cnt = 0; done_b_cnt = 0; stray = 0;
  endtask

  task automatic send(input logic [7:0] p, input logic s);
    pix_in = p; sof = s; pix_valid = 1'b1; en = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] base, input int w, input int h,
                            input bit use_sof, input bit stalls);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        send(8'(int'(base) + r * 16 + c), use_sof && r == 0 && c == 0);
        if (stalls) idle(1);
        if (stalls && r == 2 && c == 1) begin
          en = 1'b0; pix_valid = 1'b1; pix_in = 8'hEE;
          repeat (5) @(negedge clk);
          pix_valid = 1'b0; en = 1'b1;
        end
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = 8'h00;
    #12;
    total++; if (act_a !== 1'b0) begin bad++; $display("FAIL reset_act: got %b expected 0", act_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done_a); end
    total++; if (win_a !== 72'h0) begin bad++; $display("FAIL reset_win: got %h expected 0", win_a); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (act_a !== 1'b0) begin bad++; $display("FAIL reset_release_act: got %b expected 0", act_a); end
  endtask

  task automatic test_basic();
    logic [71:0] got;
    clear_mon();
    send_frame(8'h00, 4, 4, 1'b1, 1'b0);
    idle(3);
    total++; if (qa.size() != 4) begin bad++; $display("FAIL basic_count: got %0d expected 4", qa.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < qa.size()) ? qa[i] : 'x;
      total++;
      if (got !== mkwin(1 + i / 2, 1 + i % 2, 8'h00)) begin
        bad++; $display("FAIL basic_win%0d: got %h expected %h", i, got, mkwin(1 + i / 2, 1 + i % 2, 8'h00));
      end
    end
    got = (qa.size() > 0) ? qa[0] : 'x;
    total++; if (got !== 72'h000102101112202122) begin bad++; $display("FAIL basic_first: got %h expected 000102101112202122", got); end
    got = (qa.size() > 3) ? qa[3] : 'x;
    total++; if (got !== 72'h111213212223313233) begin bad++; $display("FAIL basic_last: got %h expected 111213212223313233", got); end
    total++; if (da.size() < 4 || da[3] !== 1'b1) begin bad++; $display("FAIL basic_done_with_last_act: got none expected done on 4th act"); end
    total++; if (done_a_cnt != 1) begin bad++; $display("FAIL basic_done_count: got %0d expected 1", done_a_cnt); end
  endtask

  task automatic test_stalls();
    logic [71:0] got;
    clear_mon();
    send_frame(8'h00, 4, 4, 1'b1, 1'b1);
    idle(3);
    total++; if (qa.size() != 4) begin bad++; $display("FAIL stall_count: got %0d expected 4", qa.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < qa.size()) ? qa[i] : 'x;
      total++;
      if (got !== mkwin(1 + i / 2, 1 + i % 2, 8'h00)) begin
        bad++; $display("FAIL stall_win%0d: got %h expected %h", i, got, mkwin(1 + i / 2, 1 + i % 2, 8'h00));
      end
    end
    total++; if (stray != 0) begin bad++; $display("FAIL stall_act_in_gap: got %0d expected 0", stray); end
    total++; if (done_a_cnt != 1) begin bad++; $display("FAIL stall_done_count: got %0d expected 1", done_a_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [71:0] got, exp;
    clear_mon();
    send_frame(8'h00, 4, 4, 1'b1, 1'b0);
    send_frame(8'h80, 4, 4, 1'b0, 1'b0);
    idle(3);
    total++; if (qa.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d expected 8", qa.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < qa.size()) ? qa[i] : 'x;
      exp = mkwin(1 + (i % 4) / 2, 1 + i % 2, (i < 4) ? 8'h00 : 8'h80);
      total++;
      if (got !== exp) begin bad++; $display("FAIL b2b_win%0d: got %h expected %h", i, got, exp); end
    end
    got = (qa.size() > 4) ? qa[4] : 'x;
    total++; if (got !== 72'h808182909192A0A1A2) begin bad++; $display("FAIL b2b_second_first: got %h expected 808182909192a0a1a2", got); end
    total++; if (done_a_cnt != 2) begin bad++; $display("FAIL b2b_done_count: got %0d expected 2", done_a_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [71:0] got;
    clear_mon();
    for (int k = 0; k < 11; k++) send(8'((k / 4) * 16 + k % 4), k == 0);
    total++; if (act_a !== 1'b1) begin bad++; $display("FAIL rstmid_pre_act: got %b expected 1", act_a); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (act_a !== 1'b0) begin bad++; $display("FAIL rstmid_act: got %b expected 0", act_a); end
    total++; if (win_a !== 72'h0) begin bad++; $display("FAIL rstmid_win: got %h expected 0", win_a); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    send_frame(8'h40, 4, 4, 1'b0, 1'b0);
    idle(3);
    total++; if (qa.size() != 4) begin bad++; $display("FAIL rstmid_count: got %0d expected 4", qa.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < qa.size()) ? qa[i] : 'x;
      total++;
      if (got !== mkwin(1 + i / 2, 1 + i % 2, 8'h40)) begin
        bad++; $display("FAIL rstmid_win%0d: got %h expected %h", i, got, mkwin(1 + i / 2, 1 + i % 2, 8'h40));
      end
    end
  endtask

  task automatic test_sof_resync();
    logic [71:0] got;
    clear_mon();
    for (int k = 0; k < 7; k++) send(8'((k / 4) * 16 + k % 4), 1'b0);
    send_frame(8'hC0, 4, 4, 1'b1, 1'b0);
    idle(3);
    total++; if (qa.size() != 4) begin bad++; $display("FAIL resync_count: got %0d expected 4", qa.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < qa.size()) ? qa[i] : 'x;
      total++;
      if (got !== mkwin(1 + i / 2, 1 + i % 2, 8'hC0)) begin
        bad++; $display("FAIL resync_win%0d: got %h expected %h", i, got, mkwin(1 + i / 2, 1 + i % 2, 8'hC0));
      end
    end
    total++; if (done_a_cnt != 1) begin bad++; $display("FAIL resync_done_count: got %0d expected 1", done_a_cnt); end
  endtask

  task automatic test_sof_last();
    logic [71:0] got, exp;
    clear_mon();
    for (int k = 0; k < 15; k++) send(8'((k / 4) * 16 + k % 4), k == 0);
    send_frame(8'h80, 4, 4, 1'b1, 1'b0);
    idle(3);
    total++; if (qa.size() != 7) begin bad++; $display("FAIL soflast_count: got %0d expected 7", qa.size()); end
    for (int i = 0; i < 7; i++) begin
      got = (i < qa.size()) ? qa[i] : 'x;
      exp = (i < 3) ? mkwin(1 + i / 2, 1 + i % 2, 8'h00) : mkwin(1 + (i - 3) / 2, 1 + (i - 3) % 2, 8'h80);
      total++;
      if (got !== exp) begin bad++; $display("FAIL soflast_win%0d: got %h expected %h", i, got, exp); end
    end
    total++; if (done_a_cnt != 1) begin bad++; $display("FAIL soflast_done_count: got %0d expected 1", done_a_cnt); end
    total++; if (da.size() < 7 || da[6] !== 1'b1) begin bad++; $display("FAIL soflast_done_pos: got none expected done on 7th act"); end
  endtask

  task automatic test_min_size();
    logic [71:0] got;
    clear_mon();
    send_frame(8'h00, 5, 3, 1'b1, 1'b0);
    idle(3);
    total++; if (qb.size() != 3) begin bad++; $display("FAIL min_count: got %0d expected 3", qb.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < qb.size()) ? qb[i] : 'x;
      total++;
      if (got !== mkwin(1, 1 + i, 8'h00)) begin
        bad++; $display("FAIL min_win%0d: got %h expected %h", i, got, mkwin(1, 1 + i, 8'h00));
      end
    end
    got = (qb.size() > 2) ? qb[2] : 'x;
    total++; if (got !== 72'h020304121314222324) begin bad++; $display("FAIL min_last: got %h expected 020304121314222324", got); end
    total++; if (dbq.size() < 3 || dbq[2] !== 1'b1 || dbq[0] !== 1'b0) begin bad++; $display("FAIL min_done_pos: done not only on 3rd act"); end
    total++; if (done_b_cnt != 1) begin bad++; $display("FAIL min_done_count: got %0d expected 1", done_b_cnt); end
  endtask

  initial begin
    total = 0; bad = 0;
    clear_mon();
    test_reset();
    test_basic();
    test_stalls();
    test_back_to_back();
    test_reset_mid();
    test_sof_resync();
    test_sof_last();
    test_min_size();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
